// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the program counter of the MIPS core and sequences instruction fetch.
// A four-state FSM supports free-run, single-step from a board button, and one
// hardware breakpoint. Each instruction passes FETCH (memory request until
// imem_ready) and EXEC (one-cycle commit pulse, next-PC update).
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//
// Ports
//   clk          system clock, rising edge.
//   reset        asynchronous, active-low reset.
//   run_mode     1 = free-run, 0 = single-step.
//   step         synchronized, debounced button level (rising edge used).
//   resume       single-cycle pulse that leaves HALT.
//   bp_enable    breakpoint enable.
//   bp_addr      breakpoint PC.
//   imem_req     fetch request.
//   imem_addr    fetch address (always equals pc).
//   imem_ready   read data valid this cycle.
//   imem_rdata   instruction word from memory.
//   branch_off   sign-extended branch word offset.
//   branch_c     00 none, 01 BEQ, 10 BNE, 11 never taken.
//   zero         ALU zero flag.
//   jump         J-type jump.
//   instr        latched current instruction.
//   instr_valid  commit pulse, high for the single EXEC cycle.
//   pc           current PC.
//   state        WAIT=0, FETCH=1, EXEC=2, HALT=3.
//   halted       state == HALT.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step,
    input  logic        resume,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] branch_off,
    input  logic [1:0]  branch_c,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [1:0]  state,
    output logic        halted
);

    typedef enum logic [1:0] {
        st_wait  = 2'd0,
        st_fetch = 2'd1,
        st_exec  = 2'd2,
        st_halt  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        bp_skip_q;
    logic        step_q;

    logic        step_rise;
    logic        bp_hit;
    logic        fetch_done;
    logic        br_taken;
    logic [31:0] pc4;
    logic [31:0] next_pc;

    // step_q follows the button every cycle, so an edge seen outside WAIT is
    // consumed there and never replayed later.
    assign step_rise = step & ~step_q;

    // bp_skip lets the breakpointed instruction through exactly once after
    // resume; EXEC clears it so a later return to bp_addr halts again.
    assign bp_hit     = bp_enable && (pc_q == bp_addr) && !bp_skip_q;
    assign fetch_done = imem_req && imem_ready;

    assign pc4      = pc_q + 32'd4;
    assign br_taken = ((branch_c == 2'b01) && zero) || ((branch_c == 2'b10) && !zero);

    always_comb begin
        if (jump)
            next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
        else if (br_taken)
            next_pc = pc4 + (branch_off << 2);
        else
            next_pc = pc4;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= st_wait;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_wait:  if (run_mode || step_rise) state_d = st_fetch;
            st_fetch: begin
                if (bp_hit)
                    state_d = st_halt;
                else if (imem_ready)
                    state_d = st_exec;
            end
            st_exec:  state_d = run_mode ? st_fetch : st_wait;
            st_halt:  if (resume) state_d = st_fetch;
            default:  state_d = st_wait;
        endcase
    end

    // Outputs decoded from the current state; the request is suppressed in
    // the cycle a breakpoint is detected.
    always_comb begin
        imem_req    = (state_q == st_fetch) && !bp_hit;
        instr_valid = (state_q == st_exec);
        halted      = (state_q == st_halt);
    end

    // Datapath registers: PC moves only on the edge that ends EXEC, so
    // imem_addr is stable for the whole FETCH.
    // NOTE: every register here is a small flop with a defined reset value;
    // reset forces them asynchronously, aborting any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            bp_skip_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q <= step;
            if (fetch_done)
                instr_q <= imem_rdata;
            if (state_q == st_exec) begin
                pc_q      <= next_pc;
                bp_skip_q <= 1'b0;
            end else if ((state_q == st_halt) && resume) begin
                bp_skip_q <= 1'b1;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign state     = state_q;

endmodule
